// File: rtl/active_trigger_multi.sv
// Trigger bridge between user logic and the host uc_in/uc_out bus.
// Host side frames captured rising edges per group; device side stretches host trigger commands.
module active_trigger_multi #(
    parameter int unsigned TRIG_GROUPS      = 2,
    parameter int unsigned HOLD_CYCLES      = 4,
    parameter int unsigned DEV_PULSE_CYCLES = 1
) (
    input  logic                     uc_clk,
    input  logic                     uc_reset,
    input  logic [31:0]              uc_in,
    output logic [29:0]              uc_out,
    input  logic [8*TRIG_GROUPS-1:0] trigger_to_host,
    output logic [8*TRIG_GROUPS-1:0] trigger_to_device,
    output logic [TRIG_GROUPS-1:0]   trig_pending,
    output logic                     trig_overflow
);
    localparam int unsigned NB         = 8 * TRIG_GROUPS;
    localparam logic [3:0]  CNT_LAST   = 4'(HOLD_CYCLES - 1);
    localparam logic [7:0]  PULSE_LOAD = 8'(DEV_PULSE_CYCLES);
    localparam logic [2:0]  RR_INIT    = 3'(TRIG_GROUPS - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [2:0]         rr_q, rr_d;
    logic [NB-1:0]      prev_q;
    logic [NB-1:0]      pending_q, pending_d;
    logic [NB-1:0]      rise, clr;
    logic               ovf_q, ovf_d;
    logic [29:0]        uc_out_q, uc_out_d;
    logic               cmd_prev_q;
    logic [NB-1:0][7:0] stretch_q, stretch_d;
    logic [NB-1:0]      dev_q, dev_d;

    logic [7:0][7:0]    pend8;
    logic [7:0]         grp_any;
    logic               sel_found;
    logic [2:0]         sel_grp;
    logic [2:0]         cmd_grp;
    logic [7:0]         cmd_byte;
    logic               cmd_accept;
    logic               unused_uc_in;

    function automatic logic [2:0] wrap_grp(input logic [2:0] base, input int unsigned step);
        return 3'((32'(base) + step) % TRIG_GROUPS);
    endfunction

    // Pad the pending vector to 8 groups so group selection can index it with a 3-bit value.
    assign pend8        = 64'(pending_q);
    assign unused_uc_in = ^{uc_in[31:30], uc_in[26:9]};

    always_comb begin
        grp_any = '0;
        for (int unsigned g = 0; g < 8; g++) begin
            grp_any[g] = |pend8[g];
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_grp   = '0;
        for (int unsigned i = 1; i <= TRIG_GROUPS; i++) begin
            if (!sel_found && grp_any[wrap_grp(rr_q, i)]) begin
                sel_found = 1'b1;
                sel_grp   = wrap_grp(rr_q, i);
            end
        end
    end

    always_ff @(posedge uc_clk or negedge uc_reset) begin
        if (!uc_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_q       <= RR_INIT;
            prev_q     <= '0;
            pending_q  <= '0;
            ovf_q      <= 1'b0;
            uc_out_q   <= '0;
            cmd_prev_q <= 1'b0;
            stretch_q  <= '0;
            dev_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            prev_q     <= trigger_to_host;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            uc_out_q   <= uc_out_d;
            cmd_prev_q <= uc_in[8];
            stretch_q  <= stretch_d;
            dev_q      <= dev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    rr_d    = sel_grp;
                    for (int unsigned b = 0; b < NB; b++) begin
                        clr[b] = (3'(b / 8) == sel_grp);
                    end
                end
            end
            SEND: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // uc_out is loaded from the next state so the frame appears on the edge that leaves IDLE.
    always_comb begin
        uc_out_d = '0;
        if (state_d == SEND) begin
            if (state_q == IDLE) begin
                uc_out_d = {sel_grp, 18'd0, 1'b1, pend8[sel_grp]};
            end else begin
                uc_out_d = uc_out_q;
            end
        end
    end

    // A fresh rise on a bit being framed this cycle wins over its clear.
    always_comb begin
        rise      = trigger_to_host & ~prev_q;
        pending_d = (pending_q & ~clr) | rise;
        ovf_d     = |(rise & pending_q & ~clr);
    end

    assign cmd_grp    = uc_in[29:27];
    assign cmd_byte   = uc_in[7:0];
    assign cmd_accept = uc_in[8] && !cmd_prev_q && (32'(cmd_grp) < TRIG_GROUPS);

    always_comb begin
        stretch_d = stretch_q;
        dev_d     = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (cmd_accept && cmd_byte[3'(b)] && (3'(b / 8) == cmd_grp)) begin
                stretch_d[b] = PULSE_LOAD;
            end else if (stretch_q[b] != '0) begin
                stretch_d[b] = stretch_q[b] - 8'd1;
            end
            dev_d[b] = (stretch_d[b] != '0);
        end
    end

    assign uc_out            = uc_out_q;
    assign trigger_to_device = dev_q;
    assign trig_pending      = grp_any[TRIG_GROUPS-1:0];
    assign trig_overflow     = ovf_q;

endmodule

// File: tb/tb_active_trigger_multi.sv
// Randomised scoreboard bench for active_trigger_multi (2 groups, hold 4, device pulse 3).
// A timestamp-based reference model queues expected events; a negedge monitor pops and compares.
module tb_active_trigger_multi;
    localparam int G  = 2;
    localparam int H  = 4;
    localparam int D  = 3;
    localparam int NB = 8 * G;

    typedef struct {
        int          at;
        logic [63:0] val;
    } ev_t;

    logic          clk;
    logic          rst_n;
    logic [31:0]   uc_in;
    logic [29:0]   uc_out;
    logic [NB-1:0] t2h;
    logic [NB-1:0] t2d;
    logic [G-1:0]  tpend;
    logic          tovf;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    ev_t frame_q[$];
    ev_t pend_q[$];
    ev_t dev_q[$];
    int  ovf_q[$];

    logic [NB-1:0] m_prev     = '0;
    logic [NB-1:0] m_pend     = '0;
    int            m_busy     = 0;
    int            m_rr       = G - 1;
    logic          m_cmd_prev = 1'b0;
    int            m_dl[NB];
    logic [G-1:0]  m_pv       = '0;
    logic [NB-1:0] m_dv       = '0;

    logic [29:0]   p_out = '0;
    logic [G-1:0]  p_pv  = '0;
    logic [NB-1:0] p_dv  = '0;
    logic [63:0]   cur   = '0;
    int            flen  = 0;

    active_trigger_multi #(
        .TRIG_GROUPS     (G),
        .HOLD_CYCLES     (H),
        .DEV_PULSE_CYCLES(D)
    ) dut (
        .uc_clk           (clk),
        .uc_reset         (rst_n),
        .uc_in            (uc_in),
        .uc_out           (uc_out),
        .trigger_to_host  (t2h),
        .trigger_to_device(t2d),
        .trig_pending     (tpend),
        .trig_overflow    (tovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_prev     = '0;
        m_pend     = '0;
        m_busy     = 0;
        m_rr       = G - 1;
        m_cmd_prev = 1'b0;
        m_pv       = '0;
        m_dv       = '0;
        for (int b = 0; b < NB; b++) m_dl[b] = -1;
        frame_q.delete();
        pend_q.delete();
        dev_q.delete();
        ovf_q.delete();
    endtask

    // One clock edge of the reference: decide from the pending set seen before the edge,
    // then fold in this edge's rises. The sender is busy for H frame cycles, one gap and one idle.
    task automatic model_step();
        logic [NB-1:0] h, rise, clr;
        logic [7:0]    fb;
        logic [G-1:0]  pv;
        logic [NB-1:0] dv;
        int            g, cg;
        bit            found;
        h    = t2h;
        rise = h & ~m_prev;
        clr  = '0;
        if (m_busy > 0) begin
            m_busy--;
        end else if (m_pend != '0) begin
            found = 1'b0;
            g     = 0;
            for (int k = 1; k <= G; k++) begin
                if (!found && (8'(m_pend >> (8 * ((m_rr + k) % G))) != 8'd0)) begin
                    found = 1'b1;
                    g     = (m_rr + k) % G;
                end
            end
            fb = 8'(m_pend >> (8 * g));
            frame_q.push_back('{cyc, 64'({3'(g), 18'd0, 1'b1, fb})});
            clr    = NB'(16'hFF) << (8 * g);
            m_rr   = g;
            m_busy = H + 1;
        end
        if ((rise & m_pend & ~clr) != '0) ovf_q.push_back(cyc);
        m_pend = (m_pend & ~clr) | rise;
        m_prev = h;
        for (int k = 0; k < G; k++) pv[k] = (8'(m_pend >> (8 * k)) != 8'd0);
        if (pv != m_pv) begin
            pend_q.push_back('{cyc, 64'(pv)});
            m_pv = pv;
        end
        cg = int'(uc_in[29:27]);
        if (uc_in[8] && !m_cmd_prev && cg < G) begin
            for (int b = 0; b < 8; b++) begin
                if (uc_in[b]) m_dl[cg * 8 + b] = cyc + D - 1;
            end
        end
        m_cmd_prev = uc_in[8];
        for (int b = 0; b < NB; b++) dv[b] = (m_dl[b] >= cyc);
        if (dv != m_dv) begin
            dev_q.push_back('{cyc, 64'(dv)});
            m_dv = dv;
        end
    endtask

    initial begin
        for (int b = 0; b < NB; b++) m_dl[b] = -1;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_uc_out", 64'(uc_out), 64'd0);
                check("rst_dev", 64'(t2d), 64'd0);
                check("rst_pend", 64'(tpend), 64'd0);
                check("rst_ovf", 64'(tovf), 64'd0);
                p_out = '0;
                p_pv  = '0;
                p_dv  = '0;
                flen  = 0;
            end else begin
                if (uc_out[8]) begin
                    if (!p_out[8]) begin
                        if (frame_q.size() == 0) begin
                            fail_now("frame_unexpected", 64'(uc_out), 64'd0);
                            cur = '0;
                        end else begin
                            e   = frame_q.pop_front();
                            cur = e.val;
                            check("frame_value", 64'(uc_out), e.val);
                            check("frame_cycle", 64'(cyc), 64'(e.at));
                        end
                        flen = 1;
                    end else begin
                        check("frame_hold", 64'(uc_out), cur);
                        flen++;
                    end
                end else begin
                    check("idle_zero", 64'(uc_out), 64'd0);
                    if (p_out[8]) check("hold_len", 64'(flen), 64'(H));
                end
                p_out = uc_out;

                if (tovf) begin
                    if (ovf_q.size() == 0) fail_now("ovf_unexpected", 64'd1, 64'd0);
                    else check("ovf_cycle", 64'(cyc), 64'(ovf_q.pop_front()));
                end

                if (tpend != p_pv) begin
                    if (pend_q.size() == 0) begin
                        fail_now("pend_unexpected", 64'(tpend), 64'(p_pv));
                    end else begin
                        e = pend_q.pop_front();
                        check("pend_value", 64'(tpend), e.val);
                        check("pend_cycle", 64'(cyc), 64'(e.at));
                    end
                    p_pv = tpend;
                end

                if (t2d != p_dv) begin
                    if (dev_q.size() == 0) begin
                        fail_now("dev_unexpected", 64'(t2d), 64'(p_dv));
                    end else begin
                        e = dev_q.pop_front();
                        check("dev_value", 64'(t2d), e.val);
                        check("dev_cycle", 64'(cyc), 64'(e.at));
                    end
                    p_dv = t2d;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        t2h   = '0;
        uc_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        t2h[3] = 1'b1;
        repeat (10) @(negedge clk);
        t2h[3] = 1'b0;
        repeat (4) @(negedge clk);

        repeat (2) begin
            t2h[1] = 1'b1;
            t2h[9] = 1'b1;
            repeat (16) @(negedge clk);
            t2h = '0;
            repeat (2) @(negedge clk);
        end

        t2h[8] = 1'b1;
        @(negedge clk);
        t2h[0] = 1'b1;
        @(negedge clk);
        t2h[0] = 1'b0;
        @(negedge clk);
        t2h[0] = 1'b1;
        repeat (20) @(negedge clk);
        t2h = '0;
        repeat (4) @(negedge clk);

        t2h[8] = 1'b1;
        repeat (2) @(negedge clk);
        t2h[2] = 1'b1;
        @(negedge clk);
        t2h[2] = 1'b0;
        repeat (4) @(negedge clk);
        t2h[2] = 1'b1;
        repeat (20) @(negedge clk);
        t2h = '0;
        repeat (4) @(negedge clk);

        uc_in = {2'b00, 3'd1, 18'd0, 1'b1, 8'h81};
        repeat (10) @(negedge clk);
        uc_in = '0;
        repeat (2) @(negedge clk);
        uc_in = {2'b00, 3'd5, 18'd0, 1'b1, 8'hFF};
        repeat (4) @(negedge clk);
        uc_in = '0;
        repeat (4) @(negedge clk);

        t2h[4] = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_abort", 64'(uc_out), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        t2h = '0;
        repeat (4) @(negedge clk);

        repeat (3000) begin
            @(negedge clk);
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 23) == 0) t2h[b] = ~t2h[b];
            end
            if ($urandom_range(0, 5) == 0) begin
                uc_in     = $urandom;
                uc_in[29] = ($urandom_range(0, 3) == 0);
                uc_in[28] = 1'b0;
            end
        end

        t2h   = '0;
        uc_in = '0;
        repeat (60) @(negedge clk);

        check("frames_left", 64'(frame_q.size()), 64'd0);
        check("ovf_left", 64'(ovf_q.size()), 64'd0);
        check("pend_left", 64'(pend_q.size()), 64'd0);
        check("dev_left", 64'(dev_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
